// File: rtl/aes_ctr_pkg.sv
// Shared types and AES round helpers for the CTR-mode stream encryptor.
// The round helpers target the 128-bit block with a 128-bit key schedule.
package aes_ctr_pkg;

  localparam int unsigned NbDef = 4;
  localparam int unsigned NkDef = 4;
  localparam int unsigned NrDef = 10;

  typedef logic [32*NbDef-1:0] block_t;
  typedef logic [32*NkDef-1:0] key_t;

  typedef enum logic [2:0] {StIdle, StWaitPt, StGen, StOut, StExh, StDrain} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box built as the field inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] y;
    logic [7:0] e;
    r = 8'h01;
    y = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, y);
      y = gf_mul(y, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic key_t next_round_key(input key_t rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // One full round; the final round skips MixColumns.
  function automatic block_t enc_round(input block_t s, input block_t rk, input logic last);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] a0, a1, a2, a3;
    block_t o;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last) begin
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return o ^ rk;
  endfunction

endpackage

// File: rtl/cipher.sv
// Iterative AES forward cipher: one round per cycle, round keys expanded on the fly.
// ready pulses for one cycle while ct holds the finished block.
module cipher
  import aes_ctr_pkg::*;
#(
  parameter int unsigned Nr = NrDef
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  key_t   key,
  input  block_t pt,
  output block_t ct,
  output logic   ready
);

  block_t     state_q, state_d;
  key_t       rk_q, rk_d, rk_next;
  logic [7:0] rcon_q, rcon_d;
  logic [3:0] round_q, round_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  always_comb begin
    rk_next = next_round_key(rk_q, rcon_q);
    state_d = state_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    if (busy_q) begin
      state_d = enc_round(state_q, rk_next, round_q == 4'(Nr));
      rk_d    = rk_next;
      rcon_d  = xtime(rcon_q);
      round_d = round_q + 4'd1;
      if (round_q == 4'(Nr)) begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    end else if (start) begin
      state_d = pt ^ key;
      rk_d    = key;
      rcon_d  = 8'h01;
      round_d = 4'd1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign ct    = state_q;
  assign ready = ready_q;

endmodule

// File: rtl/ctr_encrypt_stream.sv
// AES counter-mode encryptor: keystream from {Iv, ctr} XORed onto each plaintext block,
// with valid/ready streams on both sides and a sticky stop when the counter wraps.
module ctr_encrypt_stream
  import aes_ctr_pkg::*;
#(
  parameter int unsigned Nb    = NbDef,
  parameter int unsigned Nk    = NkDef,
  parameter int unsigned Nr    = NrDef,
  parameter int unsigned CTR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [32*Nk-1:0]      key,
  input  logic [32*Nb-CTR_W-1:0] Iv,
  input  logic [CTR_W-1:0]      ctr_init,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [32*Nb-1:0]      plain_text,
  output logic                  ct_valid,
  input  logic                  ct_ready,
  output logic [32*Nb-1:0]      cipher,
  output logic                  exhausted
);

  state_e                   state_q, state_d;
  logic [32*Nk-1:0]         key_q, key_d;
  logic [32*Nb-CTR_W-1:0]   iv_q, iv_d;
  logic [CTR_W-1:0]         ctr_q, ctr_d;
  logic [32*Nb-1:0]         pt_q, pt_d;
  logic [32*Nb-1:0]         cipher_q, cipher_d;
  logic                     ct_valid_q, ct_valid_d;
  logic                     exhausted_q, exhausted_d;
  logic                     core_start, core_ready;
  logic [32*Nb-1:0]         core_ct;

  cipher #(
    .Nr(Nr)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .start(core_start),
    .key  (key_q),
    .pt   ({iv_q, ctr_q}),
    .ct   (core_ct),
    .ready(core_ready)
  );

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    iv_d        = iv_q;
    ctr_d       = ctr_q;
    pt_d        = pt_q;
    cipher_d    = cipher_q;
    ct_valid_d  = ct_valid_q;
    exhausted_d = exhausted_q;
    core_start  = 1'b0;
    if (load) begin
      key_d       = key;
      iv_d        = Iv;
      ctr_d       = ctr_init;
      exhausted_d = 1'b0;
      ct_valid_d  = 1'b0;
      // A block still in flight must be flushed before the core can be restarted.
      state_d = ((state_q == StGen || state_q == StDrain) && !core_ready) ? StDrain : StWaitPt;
    end else begin
      unique case (state_q)
        StIdle, StExh: ;
        StWaitPt: begin
          if (pt_valid) begin
            pt_d       = plain_text;
            core_start = 1'b1;
            state_d    = StGen;
          end
        end
        StGen: begin
          if (core_ready) begin
            cipher_d   = core_ct ^ pt_q;
            ct_valid_d = 1'b1;
            ctr_d      = ctr_q + CTR_W'(1);
            if (&ctr_q) exhausted_d = 1'b1;
            state_d = StOut;
          end
        end
        StOut: begin
          if (ct_ready) begin
            ct_valid_d = 1'b0;
            state_d    = exhausted_q ? StExh : StWaitPt;
          end
        end
        StDrain: begin
          if (core_ready) state_d = StWaitPt;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      key_q       <= '0;
      iv_q        <= '0;
      ctr_q       <= '0;
      pt_q        <= '0;
      cipher_q    <= '0;
      ct_valid_q  <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      iv_q        <= iv_d;
      ctr_q       <= ctr_d;
      pt_q        <= pt_d;
      cipher_q    <= cipher_d;
      ct_valid_q  <= ct_valid_d;
      exhausted_q <= exhausted_d;
    end
  end

  assign pt_ready  = (state_q == StWaitPt);
  assign ct_valid  = ct_valid_q;
  assign cipher    = cipher_q;
  assign exhausted = exhausted_q;

endmodule

// File: tb/tb_ctr_encrypt_stream.sv
// Scoreboard bench for ctr_encrypt_stream: a 64-bit-counter instance for traffic and
// a 4-bit-counter instance for counter wrap; expected blocks come from a table-driven AES model.
module tb_ctr_encrypt_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic         a_rst, a_load, a_pt_valid, a_pt_ready, a_ct_valid, a_ct_ready, a_exhausted;
  logic [127:0] a_key, a_plain_text, a_cipher;
  logic [63:0]  a_iv, a_ctr_init;
  logic [1:0]   a_bp_mode;
  bit           a_rnd;

  logic         w_rst, w_load, w_pt_valid, w_pt_ready, w_ct_valid, w_ct_ready, w_exhausted;
  logic [127:0] w_key, w_plain_text, w_cipher;
  logic [123:0] w_iv;
  logic [3:0]   w_ctr_init;

  ctr_encrypt_stream #(.CTR_W(64)) u_dut_a (
    .clk(clk), .rst(a_rst), .load(a_load), .key(a_key), .Iv(a_iv), .ctr_init(a_ctr_init),
    .pt_valid(a_pt_valid), .pt_ready(a_pt_ready), .plain_text(a_plain_text),
    .ct_valid(a_ct_valid), .ct_ready(a_ct_ready), .cipher(a_cipher), .exhausted(a_exhausted)
  );

  ctr_encrypt_stream #(.CTR_W(4)) u_dut_w (
    .clk(clk), .rst(w_rst), .load(w_load), .key(w_key), .Iv(w_iv), .ctr_init(w_ctr_init),
    .pt_valid(w_pt_valid), .pt_ready(w_pt_ready), .plain_text(w_plain_text),
    .ct_valid(w_ct_valid), .ct_ready(w_ct_ready), .cipher(w_cipher), .exhausted(w_exhausted)
  );

  // ct_ready: 0 = stalled, 1 = always ready, 2 = random backpressure
  assign a_ct_ready = (a_bp_mode == 2'd2) ? a_rnd : a_bp_mode[0];
  always @(posedge clk) begin
    #2;
    a_rnd = ($urandom_range(0, 3) != 0);
  end

  // ---------------- reference AES from log/antilog tables ----------------
  logic [7:0] alog [256];
  int         lg   [256];
  logic [7:0] sb   [256];

  task automatic build_tables();
    logic [7:0] v, inv, o, c;
    v = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 255; i++) begin
      alog[i] = v;
      lg[v]   = i;
      v = v ^ {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    end
    alog[255] = alog[0];
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        o[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb[x] = o;
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return alog[(lg[a] + lg[b]) % 255];
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] blk);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   m [4];
    logic [7:0]   rc, acc;
    logic [31:0]  tmp;
    logic [127:0] out;
    m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = blk[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) s[j] = sb[s[j]];
      for (int cc = 0; cc < 4; cc++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*cc] = s[rr+4*((cc+rr)%4)];
      for (int j = 0; j < 16; j++) s[j] = t[j];
      if (r < 10) begin
        for (int cc = 0; cc < 4; cc++)
          for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j-i+4)%4], s[4*cc+j]);
            t[4*cc+i] = acc;
          end
        for (int j = 0; j < 16; j++) s[j] = t[j];
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) out[127-8*j -: 8] = s[j];
    return out;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  logic [127:0] a_q [$];
  logic [127:0] w_q [$];
  logic [127:0] a_m_key, w_m_key;
  logic [63:0]  a_m_iv, a_m_ctr;
  logic [123:0] w_m_iv;
  logic [3:0]   w_m_ctr;

  always @(negedge clk) begin
    if (a_rst && !a_load && a_ct_valid && a_ct_ready) begin
      if (a_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_ct: got %h want no block", a_cipher);
      end else check("a_ct", a_cipher, a_q.pop_front());
    end
    if (w_rst && !w_load && w_ct_valid && w_ct_ready) begin
      if (w_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w_unexpected_ct: got %h want no block", w_cipher);
      end else check("w_ct", w_cipher, w_q.pop_front());
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- drivers (all entered one time unit after a rising edge) ----------------
  task automatic a_do_load(input logic [127:0] k, input logic [63:0] iv, input logic [63:0] c);
    a_key = k; a_iv = iv; a_ctr_init = c; a_load = 1'b1;
    a_m_key = k; a_m_iv = iv; a_m_ctr = c;
    @(posedge clk); #1;
    a_load = 1'b0;
  endtask

  task automatic a_send(input logic [127:0] pt, input bit push, input bit fixed,
                        input logic [127:0] fixed_ct);
    int n;
    n = 0;
    a_plain_text = pt;
    a_pt_valid = 1'b1;
    @(negedge clk);
    while (!a_pt_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!a_pt_ready) fail_now("a_pt_accept");
    else begin
      if (push) a_q.push_back(fixed ? fixed_ct : pt ^ aes_ref(a_m_key, {a_m_iv, a_m_ctr}));
      a_m_ctr = a_m_ctr + 64'd1;
    end
    @(posedge clk); #1;
    a_pt_valid = 1'b0;
  endtask

  task automatic a_drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (a_q.size() != 0 && n < 3000);
    #1;
    if (a_q.size() != 0) fail_now("a_drain");
  endtask

  task automatic w_do_load(input logic [127:0] k, input logic [123:0] iv, input logic [3:0] c);
    w_key = k; w_iv = iv; w_ctr_init = c; w_load = 1'b1;
    w_m_key = k; w_m_iv = iv; w_m_ctr = c;
    @(posedge clk); #1;
    w_load = 1'b0;
  endtask

  task automatic w_send(input logic [127:0] pt);
    int n;
    n = 0;
    w_plain_text = pt;
    w_pt_valid = 1'b1;
    @(negedge clk);
    while (!w_pt_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!w_pt_ready) fail_now("w_pt_accept");
    else begin
      w_q.push_back(pt ^ aes_ref(w_m_key, {w_m_iv, w_m_ctr}));
      w_m_ctr = w_m_ctr + 4'd1;
    end
    @(posedge clk); #1;
    w_pt_valid = 1'b0;
  endtask

  task automatic w_drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (w_q.size() != 0 && n < 3000);
    #1;
    if (w_q.size() != 0) fail_now("w_drain");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    int n;
    build_tables();
    a_rst = 1'b0; a_load = 1'b0; a_pt_valid = 1'b0; a_key = '0; a_iv = '0; a_ctr_init = '0;
    a_plain_text = '0; a_bp_mode = 2'd1;
    w_rst = 1'b0; w_load = 1'b0; w_pt_valid = 1'b0; w_key = '0; w_iv = '0; w_ctr_init = '0;
    w_plain_text = '0; w_ct_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("a_reset_pt_ready", a_pt_ready, 1'b0);
    check1("a_reset_ct_valid", a_ct_valid, 1'b0);
    a_rst = 1'b1;
    w_rst = 1'b1;
    @(posedge clk); #1;

    // Known-answer blocks; the second carries the counter into byte 14.
    a_do_load(128'h2b7e151628aed2a6abf7158809cf4f3c, 64'hf0f1f2f3f4f5f6f7,
              64'hf8f9fafbfcfdfeff);
    a_send(128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 1'b1,
           128'h874d6191b620e3261bef6864990db6ce);
    a_send(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 1'b1,
           128'h9806f66b7970fdff8617187bb9fffdff);
    a_drain();

    // Stalled downstream.
    a_bp_mode = 2'd0;
    a_send(rnd128(), 1'b1, 1'b0, '0);
    n = 0;
    while (!a_ct_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check1("a_bp_valid_seen", a_ct_valid, 1'b1);
    held = a_cipher;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("a_bp_cipher_stable", a_cipher, held);
    check1("a_bp_valid_held", a_ct_valid, 1'b1);
    check1("a_bp_pt_ready", a_pt_ready, 1'b0);
    a_bp_mode = 2'd1;
    @(posedge clk); #1;
    check1("a_release_pt_ready", a_pt_ready, 1'b1);
    check1("a_release_ct_valid", a_ct_valid, 1'b0);

    // Abort during keystream generation: the first block must never appear.
    a_bp_mode = 2'd2;
    a_do_load(rnd128(), {$urandom, $urandom}, {$urandom, $urandom});
    a_send(rnd128(), 1'b0, 1'b0, '0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    a_do_load(rnd128(), {$urandom, $urandom}, {$urandom, $urandom});
    check1("a_abort_ct_valid", a_ct_valid, 1'b0);
    a_send(rnd128(), 1'b1, 1'b0, '0);
    a_send(rnd128(), 1'b1, 1'b0, '0);
    a_drain();

    // Random messages with idle gaps and random backpressure.
    for (int msg = 0; msg < 3; msg++) begin
      a_do_load(rnd128(), {$urandom, $urandom}, {$urandom, $urandom});
      for (int b = 0; b < 6; b++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        a_send(rnd128(), 1'b1, 1'b0, '0);
      end
      a_drain();
    end

    // Reset held for three cycles while the core is busy.
    a_bp_mode = 2'd1;
    a_send(rnd128(), 1'b0, 1'b0, '0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    a_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("a_midrst_pt_ready", a_pt_ready, 1'b0);
    check1("a_midrst_ct_valid", a_ct_valid, 1'b0);
    check1("a_midrst_exhausted", a_exhausted, 1'b0);
    check("a_midrst_cipher", a_cipher, 128'h0);
    a_rst = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    check1("a_post_rst_idle", a_pt_ready, 1'b0);
    check1("a_post_rst_no_ct", a_ct_valid, 1'b0);

    // Counter wrap on the 4-bit instance.
    w_do_load(rnd128(), {$urandom, rnd128()}, 4'he);
    w_send(rnd128());
    w_drain();
    check1("w_not_exhausted_blk1", w_exhausted, 1'b0);
    w_send(rnd128());
    w_drain();
    check1("w_exhausted_blk2", w_exhausted, 1'b1);
    check1("w_exh_pt_ready", w_pt_ready, 1'b0);
    w_pt_valid = 1'b1;
    w_plain_text = rnd128();
    repeat (6) begin
      @(posedge clk); #1;
    end
    check1("w_exh_still_blocked", w_pt_ready, 1'b0);
    check1("w_exh_no_ct", w_ct_valid, 1'b0);
    w_pt_valid = 1'b0;
    w_do_load(rnd128(), {$urandom, rnd128()}, 4'h3);
    check1("w_load_clears_exh", w_exhausted, 1'b0);
    check1("w_load_pt_ready", w_pt_ready, 1'b1);
    w_send(rnd128());
    w_drain();
    check1("w_after_reload_exh", w_exhausted, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
